ws2811_frame_ctrl: RTL and testbench
====================================

# ws2811_frame_ctrl

Frame sequencer for a WS2811 LED string. It pulls 24-bit pixel words from an upstream source over a valid/ready handshake and serialises them MSB-first into bit cells, one cell per bit, using the team's 125-cycle / 24-high / 60-high cell timing at 50 MHz. After the last pixel it holds the line low for the latch period. It sits between the pixel buffer or pattern generator and the single data pin, and owns all sequencing of the bit-cell encoder.

## Interface
Parameters:
- NUM_LEDS, 50, pixels per frame (≥1)
- BIT_PERIOD, 125, cycles per bit cell (2.5 µs)
- T0H, 24, high cycles for a 0 bit
- T1H, 60, high cycles for a 1 bit
- RESET_CYCLES, 2800, low cycles for the latch period (56 µs)

Ports:
- clk  in  1  50 MHz clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle request to send a frame
- pix_valid  in  1  upstream pixel available
- pix_data  in  24  pixel word; bit 23 is transmitted first
- pix_ready  out  1  block accepts pix_data this cycle
- dout  out  1  serial line to the LED string
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of latch
- underrun  out  1  sticky; last frame aborted for lack of data
- led_index  out  $clog2(NUM_LEDS) (min 1)  index of the pixel being shifted

## Operation
- States:
  - IDLE: waits for start.
  - FETCH: waits for the first pixel.
  - SEND: shifts bits out.
  - LATCH: holds the line low.
- Datapath: a 24-bit shift register plus a one-entry holding register (hold, hold_full).
- pix_ready = busy && !hold_full && (pixels accepted < NUM_LEDS). A transfer occurs on the edge where pix_valid && pix_ready.
- IDLE:
  - dout=0, busy=0.
  - start=1 → FETCH, busy=1, clear underrun, led_index=0.
- FETCH:
  - Waits indefinitely for hold_full; no bits have been sent yet, so the wait is harmless.
  - When hold_full: load shift←hold, clear hold_full, go to SEND at cell cycle 0, bit 23.
- SEND:
  - Each cell drives dout=1 for cell cycles 0..TxH-1 and dout=0 for TxH..BIT_PERIOD-1. TxH is T1H or T0H according to the current MSB.
  - At cell cycle BIT_PERIOD-1 of a non-final bit: shift left and start the next cell.
  - At cell cycle BIT_PERIOD-1 of bit 0:
    - If led_index==NUM_LEDS-1 → LATCH.
    - Else if hold_full: reload shift, led_index++, start the next cell with no gap.
    - Else: underrun←1 → LATCH (abort; the string latches the partial frame).
- LATCH:
  - dout=0 for RESET_CYCLES cycles.
  - On the last cycle, pulse frame_done; go to IDLE next cycle with busy=0.
- start is ignored in FETCH, SEND and LATCH, including the frame_done cycle.
- Pixels offered beyond NUM_LEDS are not accepted.
- Reset (any state): next cycle state=IDLE and all outputs 0, including underrun and led_index. hold and shift are cleared. A partially sent cell is truncated low.

## Timing
- start at edge 0 → busy=1 and pix_ready=1 from cycle 1.
- Pixel accepted at edge k (FETCH) → shift loaded at edge k+1 → first dout=1 in cycle k+2.
- Cell width is exactly BIT_PERIOD cycles. There are no idle cycles between bits or between pixels when data arrives in time.
- The next pixel can be accepted any time after the current pixel leaves hold. The latest safe acceptance is cell cycle BIT_PERIOD-2 of bit 0.
- Frame length from the first dout rise to frame_done = NUM_LEDS·24·BIT_PERIOD + RESET_CYCLES cycles, with frame_done on the final cycle.
- All outputs are registered; dout has no combinational path from inputs.

## Structure
- ws2811_pkg holds:
  - PIXEL_W=24
  - default timing constants (BIT_PERIOD, T0H, T1H, RESET_CYCLES)
  - the state enum (IDLE, FETCH, SEND, LATCH)
- Sub-module ws2811_bit_cell:
  - Ports: clk, rst_n, cell_start, bit_val, T0H/T1H/BIT_PERIOD parameters → dout, cell_last.
  - Holds the 7-bit cell counter.
  - Samples bit_val at cell_start.
  - Asserts cell_last on cycle BIT_PERIOD-1.
- The controller keeps the FSM, the bit counter (5 bits), led_index, the latch counter (12 bits), and the shift and hold registers.

## Test plan
- NUM_LEDS=2, pix_valid held high, pixels 0xFFFFFF then 0x000000 → 24 cells with 60-cycle high, then 24 cells with 24-cycle high. Every period is 125 cycles with no gap. frame_done comes 6000+2800 cycles after the first rise. underrun=0.
- Pixel 0xA50F3C → high widths follow 1010_0101_0000_1111_0011_1100, MSB first.
- NUM_LEDS=3; second pixel presented 200 cycles after the first pixel's bit-0 cell starts → underrun=1 after cell 23. dout stays low for 2800 cycles, then frame_done. The next start clears underrun.
- start pulsed during SEND and in the frame_done cycle → ignored; exactly one frame is sent.
- rst_n=0 mid-cell (dout=1) → dout=0, busy=0, pix_ready=0 the next cycle. A fresh start then produces a full frame.
- pix_valid held high after the last pixel is accepted → pix_ready stays 0 and no extra pixel is consumed.

Source files
------------

// File: rtl/ws2811_pkg.sv
// Shared constants and state encoding for the WS2811 frame sequencer.
// Timing defaults assume a 50 MHz clock.
package ws2811_pkg;

  localparam int PIXEL_W              = 24;
  localparam int DEFAULT_BIT_PERIOD   = 125;
  localparam int DEFAULT_T0H          = 24;
  localparam int DEFAULT_T1H          = 60;
  localparam int DEFAULT_RESET_CYCLES = 2800;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    LATCH
  } state_t;

endpackage

// File: rtl/ws2811_bit_cell.sv
// One WS2811 bit cell: a high pulse of T1H or T0H cycles inside a BIT_PERIOD-cycle cell.
// A new cell may be started on the cycle cell_last is high, giving back-to-back cells.
module ws2811_bit_cell #(
  parameter int BIT_PERIOD = ws2811_pkg::DEFAULT_BIT_PERIOD,
  parameter int T0H        = ws2811_pkg::DEFAULT_T0H,
  parameter int T1H        = ws2811_pkg::DEFAULT_T1H
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cell_start,
  input  logic bit_val,
  output logic dout,
  output logic cell_last
);

  logic [6:0] cnt_q, cnt_d;
  logic       bit_q, bit_d;
  logic       active_q, active_d;
  logic       dout_q, dout_d;

  assign cell_last = active_q && (cnt_q == 7'(BIT_PERIOD - 1));
  assign dout      = dout_q;

  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (cell_start) begin
      cnt_d    = '0;
      bit_d    = bit_val;
      active_d = 1'b1;
    end else if (cell_last) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q + 7'd1;
    end
    // Line level is decided from the next count so dout is a plain flop output.
    dout_d = active_d && (cnt_d < (bit_d ? 7'(T1H) : 7'(T0H)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bit_q    <= 1'b0;
      active_q <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      active_q <= active_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/ws2811_frame_ctrl.sv
// WS2811 frame sequencer: fetches pixels over valid/ready, shifts them out MSB-first
// through the bit-cell encoder, then holds the line low for the latch period.
module ws2811_frame_ctrl
  import ws2811_pkg::*;
#(
  parameter int NUM_LEDS     = 50,
  parameter int BIT_PERIOD   = DEFAULT_BIT_PERIOD,
  parameter int T0H          = DEFAULT_T0H,
  parameter int T1H          = DEFAULT_T1H,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  localparam int LIW         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pix_valid,
  input  logic [PIXEL_W-1:0] pix_data,
  output logic               pix_ready,
  output logic               dout,
  output logic               busy,
  output logic               frame_done,
  output logic               underrun,
  output logic [LIW-1:0]     led_index
);

  localparam int ACW = $clog2(NUM_LEDS + 1);

  state_t             state_q, state_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [LIW-1:0]     led_index_q, led_index_d;
  logic [11:0]        latch_cnt_q, latch_cnt_d;
  logic [PIXEL_W-1:0] shift_q, shift_d;
  logic [PIXEL_W-1:0] hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [ACW-1:0]     acc_q, acc_d;
  logic               underrun_q, underrun_d;
  logic               busy_q, busy_d;
  logic               pix_ready_q, pix_ready_d;
  logic               frame_done_q, frame_done_d;
  logic               cell_start, cell_bit, cell_last;

  ws2811_bit_cell #(
    .BIT_PERIOD(BIT_PERIOD),
    .T0H       (T0H),
    .T1H       (T1H)
  ) u_bit_cell (
    .clk       (clk),
    .rst_n     (rst_n),
    .cell_start(cell_start),
    .bit_val   (cell_bit),
    .dout      (dout),
    .cell_last (cell_last)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    led_index_d = led_index_q;
    latch_cnt_d = latch_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    acc_d       = acc_q;
    underrun_d  = underrun_q;
    cell_start  = 1'b0;
    cell_bit    = 1'b0;

    // pix_ready_q already excludes a full holding register, so no clash with a reload.
    if (pix_valid && pix_ready_q) begin
      hold_d      = pix_data;
      hold_full_d = 1'b1;
      acc_d       = acc_q + ACW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          underrun_d  = 1'b0;
          led_index_d = '0;
          acc_d       = '0;
          hold_full_d = 1'b0;
        end
      end
      FETCH: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = 5'(PIXEL_W - 1);
          cell_start  = 1'b1;
          cell_bit    = hold_q[PIXEL_W-1];
          state_d     = SEND;
        end
      end
      SEND: begin
        if (cell_last) begin
          if (bit_cnt_q != 5'd0) begin
            // Rotate rather than shift; the wrapped bits are discarded at the next reload.
            shift_d    = {shift_q[PIXEL_W-2:0], shift_q[PIXEL_W-1]};
            bit_cnt_d  = bit_cnt_q - 5'd1;
            cell_start = 1'b1;
            cell_bit   = shift_q[PIXEL_W-2];
          end else if (led_index_q == LIW'(NUM_LEDS - 1)) begin
            state_d     = LATCH;
            latch_cnt_d = '0;
          end else if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            bit_cnt_d   = 5'(PIXEL_W - 1);
            led_index_d = led_index_q + LIW'(1);
            cell_start  = 1'b1;
            cell_bit    = hold_q[PIXEL_W-1];
          end else begin
            underrun_d  = 1'b1;
            state_d     = LATCH;
            latch_cnt_d = '0;
          end
        end
      end
      LATCH: begin
        if (latch_cnt_q == 12'(RESET_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          latch_cnt_d = latch_cnt_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    pix_ready_d  = busy_d && !hold_full_d && (acc_d < ACW'(NUM_LEDS));
    frame_done_d = (state_d == LATCH) && (latch_cnt_d == 12'(RESET_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      led_index_q  <= '0;
      latch_cnt_q  <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      acc_q        <= '0;
      underrun_q   <= 1'b0;
      busy_q       <= 1'b0;
      pix_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      led_index_q  <= led_index_d;
      latch_cnt_q  <= latch_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      acc_q        <= acc_d;
      underrun_q   <= underrun_d;
      busy_q       <= busy_d;
      pix_ready_q  <= pix_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign led_index  = led_index_q;

endmodule

// File: tb/tb_ws2811_frame_ctrl.sv
// Scoreboard bench for ws2811_frame_ctrl: expected high widths are queued as pixels are
// handed over and popped as each dout pulse ends.
module tb_ws2811_frame_ctrl;

  localparam int N  = 3;
  localparam int BP = 125;
  localparam int T0 = 24;
  localparam int T1 = 60;
  localparam int RC = 2800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        dout;
  logic        busy;
  logic        frame_done;
  logic        underrun;
  logic [1:0]  led_index;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [23:0] pix_tab [3];
  int          exp_q [$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ws2811_frame_ctrl #(
    .NUM_LEDS    (N),
    .BIT_PERIOD  (BP),
    .T0H         (T0),
    .T1H         (T1),
    .RESET_CYCLES(RC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .dout      (dout),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun),
    .led_index (led_index)
  );

  // Sends one frame; late delays pixel 1 until 200 cycles into pixel 0's bit-0 cell.
  task automatic run_frame(input string name, input int npix, input bit late, input bit keep_valid,
                           input int start_off, input bit start_at_done, input bit exp_under);
    int first_rise, last_rise, done_cyc, n_done, extra, exp_len, budget, pix_i, w;
    bit have_rise, prev_dout, timed_out, in_time, ok;
    exp_len = (late ? 1 : npix) * 24 * BP + RC;
    budget  = exp_len + 1500;
    first_rise = 0; last_rise = 0; done_cyc = -1; n_done = 0; extra = 0; pix_i = 0;
    have_rise = 0; prev_dout = 0; timed_out = 1;
    @(negedge clk); start = 1'b1; pix_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || pix_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s start_resp: busy=%b pix_ready=%b, want 1 1", name, busy, pix_ready);
    end
    n_cmp++;
    if (underrun !== 1'b0 || led_index !== 2'd0) begin
      n_bad++; $display("FAIL %s start_clear: underrun=%b led_index=%0d, want 0 0", name, underrun, led_index);
    end
    for (int c = 0; c < budget; c++) begin
      if (c != 0) @(negedge clk);
      if (dout && !prev_dout) begin
        if (have_rise) begin
          n_cmp++;
          if (cyc - last_rise != BP) begin
            n_bad++; $display("FAIL %s period: got %0d cycles, want %0d", name, cyc - last_rise, BP);
          end
        end else begin
          first_rise = cyc;
        end
        have_rise = 1; last_rise = cyc;
        n_cmp++;
        if (int'(led_index) != (cyc - first_rise) / BP / 24) begin
          n_bad++; $display("FAIL %s led_index: got %0d, want %0d", name, led_index, (cyc - first_rise) / BP / 24);
        end
      end
      if (!dout && prev_dout) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL %s extra_cell: got pulse of %0d cycles, want none", name, cyc - last_rise);
        end else begin
          w = exp_q.pop_front();
          if (cyc - last_rise != w) begin
            n_bad++; $display("FAIL %s high_width: got %0d, want %0d", name, cyc - last_rise, w);
          end
        end
      end
      prev_dout = dout;
      if (frame_done) begin
        n_done++;
        if (n_done == 1) begin
          done_cyc = cyc;
          n_cmp++;
          if (!have_rise || cyc - first_rise + 1 != exp_len) begin
            n_bad++; $display("FAIL %s frame_len: got %0d, want %0d", name, cyc - first_rise + 1, exp_len);
          end
          n_cmp++;
          if (underrun !== exp_under) begin
            n_bad++; $display("FAIL %s underrun: got %b, want %b", name, underrun, exp_under);
          end
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) begin
        n_cmp++;
        if (busy !== 1'b0 || pix_ready !== 1'b0) begin
          n_bad++; $display("FAIL %s idle_after_done: busy=%b pix_ready=%b, want 0 0", name, busy, pix_ready);
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 300) begin
        timed_out = 0;
        break;
      end
      start = (start_off > 0 && have_rise && cyc == first_rise + start_off) || (start_at_done && frame_done);
      if (pix_i < npix) begin
        ok = !(late && pix_i == 1) || (have_rise && cyc >= first_rise + 23 * BP + 200);
        pix_valid = ok;
        pix_data  = pix_tab[pix_i];
      end else begin
        pix_valid = keep_valid;
        pix_data  = 24'h5A5A5A;
      end
      if (pix_valid && pix_ready) begin
        if (pix_i < npix) begin
          in_time = (pix_i == 0) || !have_rise ||
                    (cyc <= first_rise + (pix_i - 1) * 24 * BP + 23 * BP + BP - 2);
          if (in_time) begin
            for (int b = 23; b >= 0; b--) exp_q.push_back(pix_tab[pix_i][b] ? T1 : T0);
          end
          pix_i++;
        end else begin
          extra++;
        end
      end
    end
    start = 1'b0; pix_valid = 1'b0;
    if (timed_out) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no frame_done within %0d cycles, want one", name, budget);
    end
    n_cmp++;
    if (n_done != 1) begin
      n_bad++; $display("FAIL %s done_count: got %0d, want 1", name, n_done);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL %s missing_cells: got %0d unsent, want 0", name, exp_q.size());
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++; $display("FAIL %s extra_pixels: got %0d accepted, want 0", name, extra);
    end
    exp_q.delete();
    $display("frame %s: pixels_accepted=%0d done=%0d", name, pix_i, n_done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dout, busy, pix_ready, frame_done, underrun} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b, want 00000", {dout, busy, pix_ready, frame_done, underrun});
    end
    n_cmp++;
    if (led_index !== 2'd0) begin
      n_bad++; $display("FAIL reset_led_index: got %0d, want 0", led_index);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || dout !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_start: busy=%b dout=%b, want 0 0", busy, dout);
    end
    $display("reset: checked");
  endtask

  task automatic test_patterns();
    pix_tab = '{24'hFFFFFF, 24'h000000, 24'hA50F3C};
    run_frame("patterns", 3, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_underrun();
    pix_tab = '{24'h123456, 24'h654321, 24'h0F0F0F};
    run_frame("underrun", 3, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    n_cmp++;
    if (underrun !== 1'b1) begin
      n_bad++; $display("FAIL underrun_sticky: got %b, want 1", underrun);
    end
  endtask

  task automatic test_start_ignored();
    pix_tab = '{24'hA50F3C, 24'hFFFFFF, 24'h000000};
    run_frame("start_ignored", 3, 1'b0, 1'b1, 500, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_cell();
    int waited;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; pix_valid = 1'b1; pix_data = 24'hFFFFFF;
    waited = 0;
    while (dout !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (dout !== 1'b1) begin
      n_bad++; $display("FAIL mid_cell_high: dout=%b, want 1", dout);
    end
    rst_n = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({dout, busy, pix_ready} !== 3'b000) begin
      n_bad++; $display("FAIL reset_mid_cell: dout,busy,pix_ready=%b, want 000", {dout, busy, pix_ready});
    end
    n_cmp++;
    if (underrun !== 1'b0 || led_index !== 2'd0 || frame_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_cell_status: underrun=%b led_index=%0d frame_done=%b, want 0 0 0",
                        underrun, led_index, frame_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    pix_tab = '{24'h00FF00, 24'h800001, 24'h7FFFFE};
    run_frame("after_reset", 3, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    test_reset();
    test_patterns();
    test_underrun();
    test_start_ignored();
    test_reset_mid_cell();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
